// File: rtl/dm_pkg.sv
// Debug-module shared types: DTM operation codes, DMI request/response words,
// sticky dmistat error codes and the request initiator's FSM states.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_t;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_t     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        DMINoError       = 2'h0,
        DMIReservedError = 2'h1,
        DMIOPFailed      = 2'h2,
        DMIBusy          = 2'h3
    } dmi_error_t;

    typedef enum logic [1:0] {
        DMI_IDLE = 2'h0,
        DMI_REQ  = 2'h1,
        DMI_RESP = 2'h2
    } dmi_fsm_t;

endpackage

// File: rtl/dmi_req_initiator.sv
// DTM-side DMI initiator: turns a DR update into one valid/ready request,
// waits for the response and keeps the sticky dmistat error.
//
// state    | meaning
// DMI_IDLE | no transaction; accepts a DR update when dmistat is clear
// DMI_REQ  | request presented, waiting for dmi_req_ready_i
// DMI_RESP | request accepted, waiting for dmi_resp_valid_i
module dmi_req_initiator
    import dm::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          update_i,
    input  dmi_req_t      dr_i,
    input  logic          capture_i,
    output logic [40:0]   dr_o,
    input  logic          dmireset_i,
    input  logic          dmihardreset_i,
    output logic          busy_o,
    output dmi_req_t      dmi_req_o,
    output logic          dmi_req_valid_o,
    input  logic          dmi_req_ready_i,
    input  dmi_resp_t     dmi_resp_i,
    input  logic          dmi_resp_valid_i,
    output logic          dmi_resp_ready_o
);

    dmi_fsm_t    state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    dtm_op_t     op_q, op_d;
    logic [31:0] data_q, data_d;
    dmi_error_t  err_q, err_d;
    logic        discard_q, discard_d;
    logic        drop;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        data_d    = data_q;
        err_d     = err_q;
        discard_d = discard_q;
        drop      = discard_q | dmihardreset_i;

        unique case (state_q)
            DMI_IDLE: begin
                if (update_i && err_q == DMINoError &&
                    (dr_i.op == DTM_READ || dr_i.op == DTM_WRITE)) begin
                    addr_d  = dr_i.addr;
                    op_d    = dr_i.op;
                    data_d  = dr_i.data;
                    state_d = DMI_REQ;
                end
            end
            DMI_REQ: begin
                // A hard reset racing the handshake still owes the responder a
                // response slot, so it becomes a discarded transaction instead.
                if (dmi_req_ready_i) begin
                    state_d   = DMI_RESP;
                    discard_d = dmihardreset_i;
                end else if (dmihardreset_i) begin
                    state_d = DMI_IDLE;
                end
            end
            DMI_RESP: begin
                if (dmihardreset_i) discard_d = 1'b1;
                if (dmi_resp_valid_i) begin
                    if (op_q == DTM_READ && !drop) data_d = dmi_resp_i.data;
                    if (dmi_resp_i.resp != DTM_SUCCESS && !drop && err_q == DMINoError)
                        err_d = DMIOPFailed;
                    discard_d = 1'b0;
                    state_d   = DMI_IDLE;
                end
            end
            default: state_d = DMI_IDLE;
        endcase

        // A responder failure in the same cycle is the earlier error and wins.
        if ((update_i || capture_i) && state_q != DMI_IDLE && err_d == DMINoError)
            err_d = DMIBusy;
        if (dmireset_i || dmihardreset_i)
            err_d = DMINoError;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= DMI_IDLE;
            addr_q    <= '0;
            op_q      <= DTM_NOP;
            data_q    <= '0;
            err_q     <= DMINoError;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            data_q    <= data_d;
            err_q     <= err_d;
            discard_q <= discard_d;
        end
    end

    assign busy_o           = (state_q != DMI_IDLE);
    assign dmi_req_valid_o  = (state_q == DMI_REQ);
    assign dmi_resp_ready_o = (state_q == DMI_RESP);
    assign dmi_req_o        = '{addr: addr_q, op: op_q, data: data_q};
    assign dr_o             = {addr_q, data_q, err_q};

endmodule

// File: tb/tb_dmi_req_initiator.sv
// Bench for dmi_req_initiator: directed scenarios plus randomized transactions
// checked against a transaction-level model of addr/data/dmistat.
module tb_dmi_req_initiator;
    import dm::*;

    logic        clk = 1'b0;
    logic        rst, update, capture, dmireset, dmihardreset;
    logic        req_ready, resp_valid;
    dmi_req_t    dr_in, dmi_req;
    dmi_resp_t   dmi_resp;
    logic [40:0] dr_out;
    logic        busy, req_valid, resp_ready;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    logic [6:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_err;

    dmi_req_initiator dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .update_i         (update),
        .dr_i             (dr_in),
        .capture_i        (capture),
        .dr_o             (dr_out),
        .dmireset_i       (dmireset),
        .dmihardreset_i   (dmihardreset),
        .busy_o           (busy),
        .dmi_req_o        (dmi_req),
        .dmi_req_valid_o  (req_valid),
        .dmi_req_ready_i  (req_ready),
        .dmi_resp_i       (dmi_resp),
        .dmi_resp_valid_i (resp_valid),
        .dmi_resp_ready_o (resp_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [40:0] exp_dr();
        return {m_addr, m_data, m_err};
    endfunction

    task automatic garbage_dr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        dr_in = dmi_req_t'(r[40:0]);
    endtask

    task automatic pulse_dmireset();
        dmireset = 1'b1;
        step();
        dmireset = 1'b0;
        m_err = 2'd0;
    endtask

    task automatic capture_check(input string tag);
        capture = 1'b1;
        chk(tag, dr_out, exp_dr());
        step();
        capture = 1'b0;
    endtask

    // poke: 0 none, 1 capture in first REQ cycle, 2 capture / 3 update in first RESP cycle
    task automatic txn(input logic [6:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input int rdly, input int sdly, input logic [1:0] rc,
                       input logic [31:0] rd, input int poke);
        logic issue;
        int   hs0;
        issue = (m_err == 2'd0) && (op == 2'd1 || op == 2'd2);
        hs0 = hs_cnt;
        dr_in = dmi_req_t'({a, op, wd});
        update = 1'b1;
        step();
        update = 1'b0;
        garbage_dr();
        if (!issue) begin
            chk("noreq_valid", req_valid, 1'b0);
            chk("noreq_busy", busy, 1'b0);
            step();
            chk("noreq_hs", hs_cnt - hs0, 0);
        end else begin
            m_addr = a;
            m_data = wd;
            chk("req_valid", req_valid, 1'b1);
            for (int i = 0; i <= rdly; i++) begin
                chk("req_fields", dmi_req, {a, op, wd});
                chk("req_valid_hold", req_valid, 1'b1);
                capture   = (poke == 1 && i == 0);
                req_ready = (i == rdly);
                step();
            end
            capture   = 1'b0;
            req_ready = 1'b0;
            if (poke == 1 && m_err == 2'd0) m_err = 2'd3;
            chk("hs_once", hs_cnt - hs0, 1);
            chk("valid_dropped", req_valid, 1'b0);
            for (int i = 0; i <= sdly; i++) begin
                chk("resp_ready_hold", resp_ready, 1'b1);
                capture    = (poke == 2 && i == 0);
                update     = (poke == 3 && i == 0);
                resp_valid = (i == sdly);
                dmi_resp   = {rd, rc};
                step();
                capture = 1'b0;
                update  = 1'b0;
            end
            resp_valid = 1'b0;
            if (poke >= 2 && sdly > 0 && m_err == 2'd0) m_err = 2'd3;
            if (op == 2'd1) m_data = rd;
            if (rc != 2'd0 && m_err == 2'd0) m_err = 2'd2;
            if (poke >= 2 && sdly == 0 && m_err == 2'd0) m_err = 2'd3;
            chk("idle_after_resp", busy, 1'b0);
            chk("resp_ready_drop", resp_ready, 1'b0);
        end
        capture_check("capture_dr");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; update = 1'b0; capture = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; dmi_resp = '0; dr_in = '0;
        m_addr = '0; m_data = '0; m_err = '0;
        #12;
        chk("rst_dr", dr_out, 41'd0);
        chk("rst_valid", req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_ready", resp_ready, 1'b0);
        chk("rst_req", dmi_req, 41'd0);
        #10 rst = 1'b0;
        step();

        // read
        txn(7'h11, 2'd1, 32'h0, 2, 2, 2'd0, 32'hCAFE_0001, 0);
        chk("read_dr", dr_out, {7'h11, 32'hCAFE_0001, 2'b00});
        // write with ready held low for 5 cycles
        txn(7'h04, 2'd2, 32'h1234_5678, 5, 1, 2'd0, 32'hDEAD_BEEF, 0);
        chk("write_dr", dr_out, {7'h04, 32'h1234_5678, 2'b00});
        // nop does nothing
        txn(7'h55, 2'd0, 32'h1111_1111, 0, 0, 2'd0, 32'h0, 0);
        // busy: capture during RESP
        txn(7'h05, 2'd1, 32'h0, 1, 2, 2'd0, 32'hA5A5_0005, 2);
        chk("busy_status", dr_out[1:0], 2'd3);
        txn(7'h06, 2'd2, 32'h6666_6666, 0, 0, 2'd0, 32'h0, 0);
        pulse_dmireset();
        txn(7'h07, 2'd2, 32'h7777_7777, 0, 0, 2'd0, 32'h0, 0);
        chk("after_dmireset", dr_out, {7'h07, 32'h7777_7777, 2'b00});
        // responder failure, then busy attempt must not overwrite
        txn(7'h08, 2'd1, 32'h0, 0, 1, 2'd2, 32'h0808_0808, 0);
        chk("opfailed", dr_out[1:0], 2'd2);
        txn(7'h09, 2'd1, 32'h0, 0, 0, 2'd0, 32'h0, 0);
        chk("opfailed_sticky", dr_out[1:0], 2'd2);
        pulse_dmireset();

        // hard reset in REQ
        dr_in = dmi_req_t'({7'h22, 2'd1, 32'h2222_0000});
        update = 1'b1; step(); update = 1'b0;
        chk("hr_req_valid", req_valid, 1'b1);
        step();
        dmihardreset = 1'b1; step(); dmihardreset = 1'b0;
        chk("hr_req_drop", req_valid, 1'b0);
        chk("hr_req_idle", busy, 1'b0);
        m_addr = 7'h22; m_data = 32'h2222_0000; m_err = 2'd0;
        capture_check("hr_req_dr");

        // hard reset in RESP, failing read response is discarded
        dr_in = dmi_req_t'({7'h33, 2'd1, 32'h0BAD_F00D});
        update = 1'b1; step(); update = 1'b0;
        req_ready = 1'b1; step(); req_ready = 1'b0;
        chk("hr_resp_ready", resp_ready, 1'b1);
        dmihardreset = 1'b1; step(); dmihardreset = 1'b0;
        chk("hr_resp_still", resp_ready, 1'b1);
        resp_valid = 1'b1; dmi_resp = {32'hFFFF_FFFF, 2'd2};
        step(); resp_valid = 1'b0;
        chk("hr_resp_idle", busy, 1'b0);
        m_addr = 7'h33; m_data = 32'h0BAD_F00D; m_err = 2'd0;
        capture_check("hr_resp_dr");

        // randomized transactions
        for (int n = 0; n < 80; n++) begin
            int poke;
            logic [1:0] rc;
            poke = $urandom_range(0, 6);
            if (poke > 3) poke = 0;
            rc = ($urandom_range(0, 5) == 0) ? 2'(1 + $urandom_range(0, 2)) : 2'd0;
            txn(7'($urandom), 2'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), rc, $urandom, poke);
            if (m_err != 2'd0 && $urandom_range(0, 2) == 0) pulse_dmireset();
        end
        pulse_dmireset();

        // async reset mid-REQ
        dr_in = dmi_req_t'({7'h44, 2'd2, 32'h4444_4444});
        update = 1'b1; step(); update = 1'b0;
        chk("ar_valid_before", req_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", req_valid, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_dr", dr_out, 41'd0);
        #10 rst = 1'b0;
        m_addr = '0; m_data = '0; m_err = '0;
        step();
        capture_check("ar_capture");
        txn(7'h12, 2'd1, 32'h0, 1, 0, 2'd0, 32'h1234_ABCD, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
